// File: rtl/wb_dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, grant and FSM state.
// Also holds the fixed-priority arbitration function with its starvation override.
package wb_dmem_arbiter_pkg;

  localparam logic [1:0] MEM_TYPE_BYTE = 2'd0;
  localparam logic [1:0] MEM_TYPE_HALF = 2'd1;
  localparam logic [1:0] MEM_TYPE_WORD = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ITLB = 2'd1,
    GNT_DTLB = 2'd2,
    GNT_CORE = 2'd3
  } grant_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Walks outrank the core unless the core has already lost too often.
  function automatic grant_t arbitrate(input logic itlb_req, input logic dtlb_req,
                                       input logic core_req, input logic starved);
    grant_t g;
    if (starved && core_req) g = GNT_CORE;
    else if (itlb_req)       g = GNT_ITLB;
    else if (dtlb_req)       g = GNT_DTLB;
    else if (core_req)       g = GNT_CORE;
    else                     g = GNT_NONE;
    return g;
  endfunction

endpackage

// File: rtl/wb_dmem_arbiter.sv
// Shares the data memory unit between IMMU walk, DMMU walk and core load/store.
// One access at a time, grant held until completion/abort, IDLE gap between accesses.
module wb_dmem_arbiter
  import wb_dmem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_BITS     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        suspend,
  input  logic        itlb_ren,
  input  logic [31:0] itlb_addr,
  output logic        itlb_ack,
  output logic [31:0] itlb_data,
  input  logic        dtlb_ren,
  input  logic [31:0] dtlb_addr,
  output logic        dtlb_ack,
  output logic [31:0] dtlb_data,
  input  logic        core_ren,
  input  logic        core_wen,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_type,
  input  logic        core_ext,
  input  logic [31:0] core_din,
  input  logic        core_cache,
  input  logic        core_lock,
  output logic [31:0] core_dout,
  output logic        core_stall,
  output logic        mu_en_cache,
  output logic [31:0] mu_addr,
  output logic [1:0]  mu_type,
  output logic        mu_ext,
  output logic        mu_en_r,
  output logic        mu_en_w,
  output logic [31:0] mu_data_w,
  output logic        mu_lock,
  output logic        mu_suspend,
  input  logic [31:0] mu_data_r,
  input  logic        mu_stall
);

  state_t              state;
  grant_t              gnt;
  grant_t              next_gnt;
  logic [CNT_BITS-1:0] starve_cnt;

  logic core_req;
  logic any_req;
  logic starved;
  logic busy;
  logic req_live;
  logic core_gnt;
  logic core_abort;
  logic done;

  assign core_req   = core_ren | core_wen;
  assign any_req    = itlb_ren | dtlb_ren | core_req;
  assign starved    = starve_cnt >= CNT_BITS'(STARVE_LIMIT);
  assign next_gnt   = arbitrate(itlb_ren, dtlb_ren, core_req, starved);
  assign busy       = (state == ST_BUSY);
  assign core_gnt   = busy && (gnt == GNT_CORE);
  assign core_abort = core_gnt && suspend;

  // A requester that drops its request while granted aborts its own access.
  always_comb begin
    req_live = 1'b0;
    case (gnt)
      GNT_ITLB: req_live = itlb_ren;
      GNT_DTLB: req_live = dtlb_ren;
      GNT_CORE: req_live = core_req;
      default:  req_live = 1'b0;
    endcase
  end

  assign done = busy && req_live && !mu_stall && !core_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      gnt        <= GNT_NONE;
      starve_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            state <= ST_BUSY;
            gnt   <= next_gnt;
          end
        end
        default: begin
          if (!req_live || core_abort || !mu_stall) begin
            state <= ST_IDLE;
            gnt   <= GNT_NONE;
          end
        end
      endcase

      if (!core_req) begin
        starve_cnt <= '0;
      end else if (state == ST_IDLE) begin
        if (next_gnt == GNT_CORE)
          starve_cnt <= '0;
        else if (!starved)
          starve_cnt <= starve_cnt + CNT_BITS'(1);
      end
    end
  end

  always_comb begin
    mu_en_cache = 1'b0;
    mu_addr     = '0;
    mu_type     = MEM_TYPE_BYTE;
    mu_ext      = 1'b0;
    mu_en_r     = 1'b0;
    mu_en_w     = 1'b0;
    mu_data_w   = '0;
    mu_lock     = 1'b0;
    mu_suspend  = 1'b0;
    if (busy) begin
      case (gnt)
        GNT_ITLB: begin
          mu_en_cache = 1'b1;
          mu_addr     = itlb_addr;
          mu_type     = MEM_TYPE_WORD;
          mu_en_r     = itlb_ren;
        end
        GNT_DTLB: begin
          mu_en_cache = 1'b1;
          mu_addr     = dtlb_addr;
          mu_type     = MEM_TYPE_WORD;
          mu_en_r     = dtlb_ren;
        end
        GNT_CORE: begin
          mu_en_cache = core_cache;
          mu_addr     = core_addr;
          mu_type     = core_type;
          mu_ext      = core_ext;
          mu_en_r     = core_ren;
          mu_en_w     = core_wen;
          mu_data_w   = core_din;
          mu_lock     = core_lock;
          mu_suspend  = suspend;
        end
        default: ;
      endcase
    end
  end

  assign itlb_ack   = done && (gnt == GNT_ITLB);
  assign dtlb_ack   = done && (gnt == GNT_DTLB);
  assign itlb_data  = itlb_ack ? mu_data_r : '0;
  assign dtlb_data  = dtlb_ack ? mu_data_r : '0;
  assign core_dout  = (done && (gnt == GNT_CORE)) ? mu_data_r : '0;
  // An aborted core access releases the pipeline in the same cycle.
  assign core_stall = core_req && !(core_gnt && (!mu_stall || suspend));

endmodule
